// File: rtl/sub16_pkg.sv
// sub16_pkg: shared state encoding, datapath width and DIGIT legality check for sub16_serial
package sub16_pkg;
  localparam int WIDTH = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  function automatic bit digit_legal(input int d);
    return d == 1 || d == 2 || d == 4 || d == 8 || d == 16;
  endfunction
endpackage

// File: rtl/sub16_serial_fs.sv
// FullSubtractor: one-bit subtractor cell, X is borrow-in and C is borrow-out
module FullSubtractor (
  input  logic A,
  input  logic B,
  input  logic X,
  output logic S,
  output logic C
);
  assign S = A ^ B ^ X;
  assign C = (~A & B) | (~(A ^ B) & X);
endmodule

// File: rtl/sub16_serial.sv
// sub16_serial: multi-cycle 16-bit subtractor, DIGIT bits per cycle; SUB16_SIGNED_FLAGS_EN adds V and Z outputs
module sub16_serial
  import sub16_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] D,
  output logic             BW
`ifdef SUB16_SIGNED_FLAGS_EN
  ,
  output logic             V,
  output logic             Z
`endif
);
  localparam int STEPS = WIDTH / DIGIT;
  if (!digit_legal(DIGIT)) begin : g_bad_digit
    $error("sub16_serial: DIGIT must be 1, 2, 4, 8 or 16");
  end
  state_t           r_state;
  logic [4:0]       r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_d;
  logic             r_bw, r_bo;
  logic [DIGIT-1:0] w_diff;
  logic [DIGIT:0]   w_b;
  logic [WIDTH-1:0] w_d;
  logic             w_last;
  // operands shift right so the active slice always sits in the low DIGIT bits
  assign w_b[0] = r_bw;
  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    FullSubtractor u_fs (.A(r_a[i]), .B(r_b[i]), .X(w_b[i]), .S(w_diff[i]), .C(w_b[i+1]));
  end
  always_comb begin
    w_d = r_d;
    w_d[r_cnt*DIGIT +: DIGIT] = w_diff;
  end
  assign w_last = r_cnt == 5'(STEPS - 1);
`ifdef SUB16_SIGNED_FLAGS_EN
  logic r_a15, r_b15, r_v, r_z;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_a15 <= 1'b0;
      r_b15 <= 1'b0;
      r_v   <= 1'b0;
      r_z   <= 1'b0;
    end else if (r_state == IDLE && IN_VALID) begin
      r_a15 <= A[WIDTH-1];
      r_b15 <= B[WIDTH-1];
    end else if (r_state == BUSY && w_last) begin
      r_v <= (r_a15 != r_b15) && (w_d[WIDTH-1] != r_a15);
      r_z <= w_d == '0;
    end
  end
  assign V = r_v;
  assign Z = r_z;
`endif
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bw    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_d     <= '0;
      r_bo    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (IN_VALID) begin
          r_a     <= A;
          r_b     <= B;
          r_bw    <= 1'b0;
          r_cnt   <= '0;
          r_state <= BUSY;
        end
        BUSY: begin
          r_d   <= w_d;
          r_a   <= r_a >> DIGIT;
          r_b   <= r_b >> DIGIT;
          r_bw  <= w_b[DIGIT];
          r_cnt <= r_cnt + 5'd1;
          if (w_last) begin
            r_bo    <= w_b[DIGIT];
            r_state <= DONE;
          end
        end
        DONE: if (OUT_READY) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign IN_READY  = r_state == IDLE;
  assign OUT_VALID = r_state == DONE;
  assign D         = r_d;
  assign BW        = r_bo;
endmodule

// File: tb/tb_sub16_serial.sv
// tb_sub16_serial: directed vector table plus backpressure, mid-op reset, DIGIT=1 and random streaming checks
module tb_sub16_serial;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0, in_ready, out_valid, bw;
  logic [15:0] a = '0, b = '0, d;
  logic in_valid1 = 1'b0, out_ready1 = 1'b0, in_ready1, out_valid1, bw1;
  logic [15:0] a1 = '0, b1 = '0, d1;
`ifdef SUB16_SIGNED_FLAGS_EN
  logic v, z, v1, z1;
`endif
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;

  sub16_serial #(.DIGIT(4)) dut (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready), .A(a), .B(b),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .D(d), .BW(bw)
`ifdef SUB16_SIGNED_FLAGS_EN
    , .V(v), .Z(z)
`endif
  );
  sub16_serial #(.DIGIT(1)) dut1 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid1), .IN_READY(in_ready1), .A(a1), .B(b1),
    .OUT_VALID(out_valid1), .OUT_READY(out_ready1), .D(d1), .BW(bw1)
`ifdef SUB16_SIGNED_FLAGS_EN
    , .V(v1), .Z(z1)
`endif
  );

  typedef struct {
    logic [15:0] a, b, d;
    logic bw, v, z;
    string nm;
  } vec_t;
  typedef struct packed {logic [15:0] a, b;} pair_t;
  vec_t vecs[8];
  pair_t q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input vec_t t);
    int lat = 0;
    while (!in_ready && lat < 50) begin tick(); lat++; end
    a = t.a; b = t.b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    chk({t.nm, "_lat"}, lat, 4);
    chk({t.nm, "_d"}, d, t.d);
    chk({t.nm, "_bw"}, bw, t.bw);
`ifdef SUB16_SIGNED_FLAGS_EN
    chk({t.nm, "_v"}, v, t.v);
    chk({t.nm, "_z"}, z, t.z);
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({t.nm, "_rdy"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    vecs[0] = '{16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 1'b0, "basic"};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, "equal"};
    vecs[2] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0, "under"};
    vecs[3] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0, "sovf_neg"};
    vecs[4] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0, "sovf_pos"};
    vecs[5] = '{16'h0000, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, "zero_max"};
    vecs[6] = '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0, "small"};
    vecs[7] = '{16'h0100, 16'h0001, 16'h00FF, 1'b0, 1'b0, 1'b0, "ripple"};
    tick(); tick();
    rst = 1'b0;
    chk("reset_state", {in_ready, out_valid, bw, d}, {1'b1, 1'b0, 1'b0, 16'h0000});
    for (int i = 0; i < 8; i++) run_op(vecs[i]);

    begin : backpressure
      int lat = 0;
      a = 16'h00F0; b = 16'h0F00; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      while (!out_valid && lat < 50) begin tick(); lat++; end
      chk("bp_d", {bw, d}, {1'b1, 16'hF1F0});
      for (int k = 0; k < 10; k++) begin
        in_valid = k[0]; a = 16'h1111; b = 16'h2222;
        tick();
        chk("bp_hold", {out_valid, in_ready, bw, d}, {1'b1, 1'b0, 1'b1, 16'hF1F0});
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_release", {out_valid, in_ready}, 2'b01);
    end

    begin : midreset
      a = 16'hABCD; b = 16'h1234; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_reset", {in_ready, out_valid, bw, d}, {1'b1, 1'b0, 1'b0, 16'h0000});
      run_op(vecs[6]);
    end

    begin : digit1
      int lat = 0;
      a1 = 16'h0000; b1 = 16'h0001; in_valid1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      while (!out_valid1 && lat < 50) begin tick(); lat++; end
      chk("d1_lat", lat, 16);
      chk("d1_res", {bw1, d1}, {1'b1, 16'hFFFF});
      out_ready1 = 1'b1;
      tick();
      out_ready1 = 1'b0;
      chk("d1_rdy", {out_valid1, in_ready1}, 2'b01);
    end

    begin : stream
      int sent = 0, got = 0, cyc = 0;
      logic [15:0] na = 16'($urandom), nb = 16'($urandom);
      pair_t p;
      while (got < 100 && cyc < 20000) begin
        tick();
        cyc++;
        out_ready = 1'($urandom_range(0, 1));
        in_valid = (sent < 100) && ($urandom_range(0, 3) != 0);
        a = na; b = nb;
        #1;
        if (in_valid && in_ready) begin
          q.push_back('{na, nb});
          sent++;
          na = 16'($urandom); nb = 16'($urandom);
        end
        if (out_valid && out_ready) begin
          got++;
          if (q.size() == 0) chk("stream_extra", 1, 0);
          else begin
            p = q.pop_front();
            chk("stream_res", {bw, d}, {p.a < p.b, 16'(p.a - p.b)});
          end
        end
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("stream_count", got, 100);
      chk("stream_left", q.size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
